jtag_tap_datapath: RTL
======================

Name: jtag_tap_datapath

Overview:
- Downstream consumer of the 4-bit TAP controller state. Uses that state with TDI to run the JTAG instruction register and data registers: BYPASS, IDCODE and one USER register.
- Drives TDO/TDO-enable off-chip and exposes the decoded instruction, plus a user parallel port, to the core.
- Single clock domain: CLK is TCK. Every action happens on the rising CLK edge that leaves the corresponding TAP state (IEEE 1149.1 semantics).

Parameters:
- IR_LEN, 4, instruction register width (>=2)
- IDCODE_VAL, 32'h1234_5679, device ID; bit0 must be 1
- IDCODE_OP, 4'b0001, IDCODE opcode; also the reset instruction
- USER_OP, 4'b1000, opcode selecting the USER DR
- USER_LEN, 8, USER data register width (>=1)

Ports:
- CLK  in  1  TCK
- RESETN  in  1  asynchronous, active-low reset
- state  in  4  current TAP state from the TAP FSM
- tdi  in  1  serial data in
- tdo  out  1  serial data out
- tdo_en  out  1  high only in Shift-DR/Shift-IR
- instr  out  IR_LEN  active instruction
- user_capture  in  USER_LEN  parallel value loaded at Capture-DR when USER selected
- user_dout  out  USER_LEN  parallel value latched at Update-DR when USER selected
- user_update  out  1  one-cycle pulse on USER Update-DR

Behaviour:
- State encoding (jtag_pkg):
  - TLR=15, RTI=12, SELDR=7, SELIR=4
  - CAPDR=6, SHDR=2, EX1DR=1, PAUDR=3, EX2DR=0, UPDR=5
  - CAPIR=14, SHIR=10, EX1IR=9, PAUIR=11, EX2IR=8, UPIR=13
- Async reset (RESETN low): instr=IDCODE_OP; ir_sr={0..,01}; bypass=0; idcode_sr=0; user_sr=0; user_dout=0; user_update=0. Reset overrides all else, including mid-shift.
- Edge while state==TLR: instr<=IDCODE_OP. user_dout is retained.
- IR path:
  - CAPIR: ir_sr<={0..,2'b01}.
  - SHIR: ir_sr<={tdi, ir_sr[IR_LEN-1:1]}.
  - UPIR: instr<=ir_sr.
  - All other states: ir_sr holds.
- DR select from instr:
  - all-ones selects BYPASS.
  - IDCODE_OP selects IDCODE.
  - USER_OP selects USER.
  - Any other opcode selects BYPASS.
- DR path, acting on the selected register only:
  - CAPDR: bypass<=0; idcode_sr<=IDCODE_VAL; user_sr<=user_capture.
  - SHDR: right shift with tdi entering the MSB. BYPASS is 1 bit deep.
  - UPDR with USER selected: user_dout<=user_sr, and user_update=1 for the following cycle only.
- Pause, Exit, Select and RTI states hold every shift register unchanged, whatever tdi does.
- tdo is combinational from registers:
  - SHIR: ir_sr[0].
  - SHDR: LSB of the selected DR.
  - Otherwise 0.
- tdo_en = (state==SHDR)||(state==SHIR).
- Latency:
  - The first Shift cycle presents the captured LSB on tdo.
  - BYPASS delays tdi by exactly 1 cycle.
  - A full register round trip takes the register length in cycles.
- instr changes only at UPIR, TLR or reset. It never changes during Shift.

Decomposition:
- jtag_pkg: 4-bit TAP state localparams (shared with the TAP FSM), plus BYPASS opcode generation as all-ones of IR_LEN.
- Sub-module jtag_shift_reg (params WIDTH, CAPTURE-value input; inputs capture, shift, tdi; outputs q, so). Instantiated for IR, IDCODE and USER. BYPASS is inline.

Test Plan:
- IDCODE read:
  - Stimulus: reset, then states TLR→RTI→SELDR→CAPDR→32×SHDR with tdi=0.
  - Response: tdo LSB-first = 32'h1234_5679; tdo_en high exactly 32 cycles.
- IR capture and BYPASS:
  - Stimulus: CAPIR→4×SHIR with tdi=1; tdo reads 1,0,0,0. Then EX1IR→UPIR. Then CAPDR→SHDR×5 with tdi=1,0,1,1,0.
  - Response: instr=4'b1111; tdo=0,1,0,1,1.
- USER update:
  - Stimulus: load instr=4'b1000; user_capture=8'hA5; CAPDR→8×SHDR shifting tdi=8'h3C LSB-first→EX1DR→UPDR.
  - Response: tdo streams A5 LSB-first; user_dout=8'h3C; user_update high one cycle after UPDR, 0 otherwise.
- Pause hold:
  - Stimulus: IDCODE, shift 3 bits, then EX1DR→5×PAUDR with tdi toggling→EX2DR→SHDR.
  - Response: next tdo = bit3 of 32'h1234_5679 (=1). No corruption.
- Reset paths:
  - Stimulus A: drop RESETN mid-SHDR.
  - Response A: instr=IDCODE_OP, user_dout=0, tdo_en=0 immediately.
  - Stimulus B: with user_dout=8'h3C, pass through TLR state.
  - Response B: instr=IDCODE_OP, user_dout stays 8'h3C.
- Unknown opcode:
  - Stimulus: instr=4'b0110, then shift DR with tdi=1.
  - Response: 1-bit BYPASS behaviour; first tdo=0, then 1.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding (common with the TAP FSM),
// data-register selection and the all-ones BYPASS opcode helper.
package jtag_pkg;

  typedef enum logic [3:0] {
    EX2DR = 4'd0,
    EX1DR = 4'd1,
    SHDR  = 4'd2,
    PAUDR = 4'd3,
    SELIR = 4'd4,
    UPDR  = 4'd5,
    CAPDR = 4'd6,
    SELDR = 4'd7,
    EX2IR = 4'd8,
    EX1IR = 4'd9,
    SHIR  = 4'd10,
    PAUIR = 4'd11,
    RTI   = 4'd12,
    UPIR  = 4'd13,
    CAPIR = 4'd14,
    TLR   = 4'd15
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER
  } dr_sel_e;

  // Caller truncates to the IR width; valid for widths 1..64.
  function automatic logic [63:0] all_ones(input int unsigned n);
    logic [63:0] ones;
    ones = '1;
    return ones >> (64 - n);
  endfunction

endpackage

// File: rtl/jtag_shift_reg.sv
// Capture/shift register used for the IR and the multi-bit data registers.
// Shifts right with tdi entering the MSB; so is the current LSB.
module jtag_shift_reg #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] capture_val,
  input  logic             capture,
  input  logic             shift,
  input  logic             tdi,
  output logic [WIDTH-1:0] q,
  output logic             so
);

  logic [WIDTH:0] ext;

  // Widening by one bit keeps the shift expression legal for WIDTH == 1.
  assign ext = {tdi, q};
  assign so  = q[0];

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      q <= RESET_VAL;
    end else if (capture) begin
      q <= capture_val;
    end else if (shift) begin
      q <= ext[WIDTH:1];
    end
  end

endmodule

// File: rtl/jtag_tap_datapath.sv
// JTAG TAP datapath: instruction register plus BYPASS, IDCODE and USER data
// registers, driven by the TAP controller state on TCK (CLK).
module jtag_tap_datapath
  import jtag_pkg::*;
#(
  parameter int unsigned          IR_LEN     = 4,
  parameter logic [31:0]          IDCODE_VAL = 32'h1234_5679,
  parameter logic [IR_LEN-1:0]    IDCODE_OP  = 4'b0001,
  parameter logic [IR_LEN-1:0]    USER_OP    = 4'b1000,
  parameter int unsigned          USER_LEN   = 8
) (
  input  logic                CLK,
  input  logic                RESETN,
  input  logic [3:0]          state,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic [IR_LEN-1:0]   instr,
  input  logic [USER_LEN-1:0] user_capture,
  output logic [USER_LEN-1:0] user_dout,
  output logic                user_update
);

  localparam logic [IR_LEN-1:0] BYPASS_OP = IR_LEN'(all_ones(IR_LEN));
  localparam logic [IR_LEN-1:0] IR_CAP    = IR_LEN'(1);

  tap_state_e          tap;
  dr_sel_e             dr_sel;
  logic [IR_LEN-1:0]   ir_sr;
  logic                ir_so;
  logic [31:0]         idcode_sr;
  logic                idcode_so;
  logic [USER_LEN-1:0] user_sr;
  logic                user_so;
  logic                bypass;
  logic                in_capdr;
  logic                in_shdr;

  assign tap      = tap_state_e'(state);
  assign in_capdr = (tap == CAPDR);
  assign in_shdr  = (tap == SHDR);

  // All-ones is tested first so it wins even if another opcode aliases it.
  always_comb begin
    dr_sel = DR_BYPASS;
    if (instr == BYPASS_OP) begin
      dr_sel = DR_BYPASS;
    end else if (instr == IDCODE_OP) begin
      dr_sel = DR_IDCODE;
    end else if (instr == USER_OP) begin
      dr_sel = DR_USER;
    end
  end

  jtag_shift_reg #(
    .WIDTH     (IR_LEN),
    .RESET_VAL (IR_CAP)
  ) u_ir (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .capture_val (IR_CAP),
    .capture     (tap == CAPIR),
    .shift       (tap == SHIR),
    .tdi         (tdi),
    .q           (ir_sr),
    .so          (ir_so)
  );

  jtag_shift_reg #(
    .WIDTH     (32),
    .RESET_VAL ('0)
  ) u_idcode (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .capture_val (IDCODE_VAL),
    .capture     (in_capdr && (dr_sel == DR_IDCODE)),
    .shift       (in_shdr && (dr_sel == DR_IDCODE)),
    .tdi         (tdi),
    .q           (idcode_sr),
    .so          (idcode_so)
  );

  jtag_shift_reg #(
    .WIDTH     (USER_LEN),
    .RESET_VAL ('0)
  ) u_user (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .capture_val (user_capture),
    .capture     (in_capdr && (dr_sel == DR_USER)),
    .shift       (in_shdr && (dr_sel == DR_USER)),
    .tdi         (tdi),
    .q           (user_sr),
    .so          (user_so)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      bypass <= 1'b0;
    end else if (dr_sel == DR_BYPASS) begin
      if (in_capdr) begin
        bypass <= 1'b0;
      end else if (in_shdr) begin
        bypass <= tdi;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      instr <= IDCODE_OP;
    end else if (tap == TLR) begin
      instr <= IDCODE_OP;
    end else if (tap == UPIR) begin
      instr <= ir_sr;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      user_dout   <= '0;
      user_update <= 1'b0;
    end else begin
      user_update <= (tap == UPDR) && (dr_sel == DR_USER);
      if ((tap == UPDR) && (dr_sel == DR_USER)) begin
        user_dout <= user_sr;
      end
    end
  end

  // Output enable and data are forced off while reset is asserted, even if
  // the TAP state input still shows a Shift state.
  always_comb begin
    tdo    = 1'b0;
    tdo_en = RESETN && ((tap == SHDR) || (tap == SHIR));
    if (RESETN) begin
      case (tap)
        SHIR: tdo = ir_so;
        SHDR: begin
          case (dr_sel)
            DR_IDCODE: tdo = idcode_so;
            DR_USER:   tdo = user_so;
            default:   tdo = bypass;
          endcase
        end
        default: tdo = 1'b0;
      endcase
    end
  end

endmodule
